regfile_wb_arbiter: RTL

Write-side front end for the CPU general-purpose register file. It merges writeback results from two producers, the EXU (ALU/CSR results) and the LSU (load data), onto the register file's single write port. It also keeps a per-register pending-write scoreboard so the decode stage can detect RAW hazards. It sits between the EXU/LSU result buses and the register file wdata/waddr/wen inputs.

---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port front end: round-robin merge of EXU and LSU writebacks
// onto one registered write port, plus a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [31:0]           retire_cnt
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic                  rr_lsu_r;
    logic [CNT_WIDTH-1:0]  pend_cnt_r [NUM_REGS];
    logic                  grant_exu_s;
    logic                  grant_lsu_s;
    logic                  xfer_s;
    logic                  iss_fire_s;
    logic [ADDR_WIDTH-1:0] sel_rd_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic [NUM_REGS-1:0]   inc_s;
    logic [NUM_REGS-1:0]   dec_s;

    // Grant: the pointer only matters when both producers compete.
    always_comb begin
        grant_exu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if (reset) begin
            grant_exu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end else if (exu_valid && lsu_valid) begin
            grant_exu_s = !rr_lsu_r;
            grant_lsu_s = rr_lsu_r;
        end else begin
            grant_exu_s = exu_valid;
            grant_lsu_s = lsu_valid;
        end
    end

    // Result mux toward the write-port register.
    always_comb begin
        sel_rd_s   = exu_rd;
        sel_data_s = exu_data;
        if (grant_lsu_s) begin
            sel_rd_s   = lsu_rd;
            sel_data_s = lsu_data;
        end else begin
            sel_rd_s   = exu_rd;
            sel_data_s = exu_data;
        end
    end

    assign exu_ready  = grant_exu_s;
    assign lsu_ready  = grant_lsu_s;
    assign xfer_s     = grant_exu_s | grant_lsu_s;
    assign iss_ready  = !reset && (pend_cnt_r[iss_rd] != CNT_MAX);
    assign iss_fire_s = iss_valid && iss_ready;
    // Busy reads registered counters only; a same-cycle write is not bypassed.
    assign rs1_busy   = (pend_cnt_r[rs1_addr] != CNT_ZERO);
    assign rs2_busy   = (pend_cnt_r[rs2_addr] != CNT_ZERO);

    // Per-register increment/decrement requests; x0 never increments.
    always_comb begin
        inc_s = {NUM_REGS{1'b0}};
        dec_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_s[i] = iss_fire_s && (iss_rd == ADDR_WIDTH'(i)) && (i != 32'sd0);
            dec_s[i] = rf_wen && (rf_waddr == ADDR_WIDTH'(i));
        end
    end

    // Registered write port and retire counter; x0 is retired but not written.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= ADDR_ZERO;
            rf_wdata   <= DATA_ZERO;
            retire_cnt <= 32'd0;
        end else if (xfer_s) begin
            rf_wen     <= (sel_rd_s != ADDR_ZERO);
            retire_cnt <= retire_cnt + 32'd1;
            if (sel_rd_s != ADDR_ZERO) begin
                rf_waddr <= sel_rd_s;
                rf_wdata <= sel_data_s;
            end
        end else begin
            rf_wen <= 1'b0;
        end
    end

    // Round-robin pointer flips only on contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_lsu_r <= 1'b0;
        end else if (exu_valid && lsu_valid) begin
            rr_lsu_r <= !rr_lsu_r;
        end
    end

    // Pending-write counters: saturate at max, never underflow, net-zero on collision.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset || (i == 32'sd0)) begin
                pend_cnt_r[i] <= CNT_ZERO;
            end else if (inc_s[i] && !dec_s[i] && (pend_cnt_r[i] != CNT_MAX)) begin
                pend_cnt_r[i] <= pend_cnt_r[i] + CNT_ONE;
            end else if (dec_s[i] && !inc_s[i] && (pend_cnt_r[i] != CNT_ZERO)) begin
                pend_cnt_r[i] <= pend_cnt_r[i] - CNT_ONE;
            end
        end
    end
endmodule
